// File: rtl/qpd_demod_pkg.sv
// qpd_demod_pkg: shared widths, types and the mixer round/saturate helper for the QPD demod chain
package qpd_demod_pkg;
  localparam int SIGNAL_BITS = 24;
  localparam int REF_BITS = 16;
  localparam int REF_FRAC_BITS = 14;
  localparam int PROD_BITS = SIGNAL_BITS + REF_BITS;
  typedef logic signed [SIGNAL_BITS-1:0] sample_t;
  typedef logic signed [REF_BITS-1:0] ref_t;
  typedef logic signed [PROD_BITS-1:0] prod_t;
  typedef enum logic {IDLE, WAIT} seq_state_e;
  localparam prod_t HALF = prod_t'(1) <<< (REF_FRAC_BITS - 1);
  localparam prod_t P_MAX = prod_t'(2**(SIGNAL_BITS-1) - 1);
  localparam prod_t P_MIN = -P_MAX - prod_t'(1);
  function automatic sample_t sat_round(input prod_t p);
    prod_t r;
    r = (p + HALF) >>> REF_FRAC_BITS;
    return r > P_MAX ? P_MAX[SIGNAL_BITS-1:0] : r < P_MIN ? P_MIN[SIGNAL_BITS-1:0] : r[SIGNAL_BITS-1:0];
  endfunction
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO of mixed samples with a combinational head read
module sample_fifo
  import qpd_demod_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk_i,
  input  logic    reset_i,
  input  logic    push,
  input  sample_t din,
  input  logic    pop,
  output sample_t head,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  sample_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic wr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr = push && (!full || pop);
  assign head = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk_i)
    if (wr) mem[wr_ptr[AW-1:0]] <= din;
  always_ff @(posedge clk_i)
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
endmodule

// File: rtl/qpd_fir_sequencer.sv
// qpd_fir_sequencer: mixes ADC with reference, buffers the products and runs them through the FIR start/done handshake
module qpd_fir_sequencer
  import qpd_demod_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          adc_valid_i,
  input  logic signed [SIGNAL_BITS-1:0] adc_i,
  input  logic signed [REF_BITS-1:0]    ref_i,
  output logic                          start_o,
  output logic signed [SIGNAL_BITS-1:0] sample_o,
  input  logic                          filt_done_i,
  input  logic signed [SIGNAL_BITS-1:0] filt_signal_i,
  output logic                          result_valid_o,
  output logic signed [SIGNAL_BITS-1:0] result_o,
  output logic                          busy_o,
  output logic                          overflow_o,
  output logic                          timeout_o,
  input  logic                          clear_i
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  seq_state_e state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic pop, full, empty, terminal, done;
  prod_t prod;
  sample_t mixed, head;
  assign prod = prod_t'(adc_i) * prod_t'(ref_i);
  assign mixed = sat_round(prod);
  // The FIFO storage is the mixer's registered stage: products land in it on the edge after adc_valid_i
  sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push   (adc_valid_i),
    .din    (mixed),
    .pop    (pop),
    .head   (head),
    .full   (full),
    .empty  (empty)
  );
  always_comb begin
    pop = state == IDLE && !empty;
    done = state == WAIT && filt_done_i;
    terminal = state == WAIT && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    state_nx = pop ? WAIT : (done || terminal) ? IDLE : state;
  end
  assign busy_o = state != IDLE || !empty;
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state <= IDLE;
      cnt <= '0;
      start_o <= 1'b0;
      sample_o <= '0;
      result_valid_o <= 1'b0;
      result_o <= '0;
      overflow_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= (state == WAIT && state_nx == WAIT) ? cnt + 1'b1 : '0;
      start_o <= pop;
      if (pop) sample_o <= head;
      result_valid_o <= done;
      if (done) result_o <= filt_signal_i;
      overflow_o <= (adc_valid_i && full && !pop) || (overflow_o && !clear_i);
      timeout_o <= (terminal && !filt_done_i) || (timeout_o && !clear_i);
    end
endmodule

// File: tb/tb_qpd_fir_sequencer.sv
// tb_qpd_fir_sequencer: directed and randomized checks of the mixer, FIFO, handshake and sticky flags
module tb_qpd_fir_sequencer;
  logic clk = 1'b0, reset_i = 1'b1;
  logic adc_valid_i = 1'b0, filt_done_i = 1'b0, clear_i = 1'b0;
  logic signed [23:0] adc_i = '0, filt_signal_i = '0;
  logic signed [15:0] ref_i = '0;
  logic start_o, result_valid_o, busy_o, overflow_o, timeout_o;
  logic signed [23:0] sample_o, result_o;
  int checks = 0, passed = 0;
  logic signed [23:0] exp_q [$];

  qpd_fir_sequencer dut (
    .clk_i(clk), .reset_i(reset_i), .adc_valid_i(adc_valid_i), .adc_i(adc_i), .ref_i(ref_i),
    .start_o(start_o), .sample_o(sample_o), .filt_done_i(filt_done_i), .filt_signal_i(filt_signal_i),
    .result_valid_o(result_valid_o), .result_o(result_o), .busy_o(busy_o),
    .overflow_o(overflow_o), .timeout_o(timeout_o), .clear_i(clear_i)
  );

  always #5 clk = ~clk;

  function automatic logic signed [23:0] mix_model(input logic signed [23:0] a, input logic signed [15:0] r);
    longint p, q;
    p = longint'(a) * longint'(r) + 8192;
    q = p / 16384;
    if (p % 16384 != 0 && p < 0) q = q - 1;
    if (q > 8388607) q = 8388607;
    if (q < -8388608) q = -8388608;
    return q[23:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, expv);
  endtask

  task automatic send(input logic signed [23:0] a, input logic signed [15:0] r, input bit keep);
    adc_valid_i = 1'b1;
    adc_i = a;
    ref_i = r;
    if (keep) exp_q.push_back(mix_model(a, r));
    tick;
    adc_valid_i = 1'b0;
  endtask

  task automatic await_start;
    int n = 0;
    while (!start_o && n < 300) begin
      tick;
      n++;
    end
    check("start_seen", 24'(start_o), 24'd1);
  endtask

  task automatic respond(input logic signed [23:0] f, input int delay);
    logic signed [23:0] s;
    s = exp_q.pop_front();
    check("sample", sample_o, s);
    repeat (delay) tick;
    check("sample_hold", sample_o, s);
    filt_done_i = 1'b1;
    filt_signal_i = f;
    tick;
    filt_done_i = 1'b0;
    check("result_valid", 24'(result_valid_o), 24'd1);
    check("result", result_o, f);
    tick;
    check("result_pulse", 24'(result_valid_o), 24'd0);
    if (exp_q.size() > 0) check("next_start", 24'(start_o), 24'd1);
  endtask

  initial begin
    logic signed [23:0] a;
    logic signed [15:0] r;
    tick;
    tick;
    check("rst_start", 24'(start_o), 24'd0);
    check("rst_busy", 24'(busy_o), 24'd0);
    check("rst_sample", sample_o, 24'd0);
    check("rst_result", result_o, 24'd0);
    check("rst_flags", {21'd0, result_valid_o, overflow_o, timeout_o}, 24'd0);
    reset_i = 1'b0;
    tick;
    send(24'sd1000, 16'sd8192, 1'b1);
    check("lat_n1", 24'(start_o), 24'd0);
    tick;
    check("lat_n2", 24'(start_o), 24'd1);
    check("busy", 24'(busy_o), 24'd1);
    tick;
    check("start_pulse", 24'(start_o), 24'd0);
    respond(24'sd123, 0);
    check("idle_busy", 24'(busy_o), 24'd0);
    check("result_keep", result_o, 24'sd123);
    send(24'sd3, 16'sd8192, 1'b1);
    await_start;
    respond(24'sd1, 1);
    send(-24'sd3, 16'sd8192, 1'b1);
    await_start;
    respond(24'sd2, 2);
    send(24'sd8388607, 16'sd32767, 1'b1);
    await_start;
    respond(24'sd3, 0);
    send(-24'sd8388608, 16'sd32767, 1'b1);
    await_start;
    respond(24'sd4, 0);
    for (int i = 0; i < 20; i++) begin
      a = 24'($urandom);
      r = 16'($urandom);
      send(a, r, 1'b1);
      await_start;
      respond(24'($urandom), int'($urandom_range(0, 5)));
    end
    for (int i = 0; i < 10; i++) begin
      a = 24'($urandom);
      r = 16'($urandom);
      send(a, r, i < 9);
      if (i == 8) check("no_ovf_yet", 24'(overflow_o), 24'd0);
    end
    check("overflow", 24'(overflow_o), 24'd1);
    check("buffered", 24'(exp_q.size()), 24'd9);
    respond(24'($urandom), 3);
    while (exp_q.size() > 0) respond(24'($urandom), int'($urandom_range(0, 3)));
    check("ovf_sticky", 24'(overflow_o), 24'd1);
    clear_i = 1'b1;
    tick;
    clear_i = 1'b0;
    check("ovf_clear", 24'(overflow_o), 24'd0);
    send(24'sd5000, -16'sd16384, 1'b1);
    await_start;
    check("to_sample", sample_o, exp_q.pop_front());
    repeat (255) tick;
    check("to_early", 24'(timeout_o), 24'd0);
    tick;
    check("to_set", 24'(timeout_o), 24'd1);
    check("to_no_result", 24'(result_valid_o), 24'd0);
    send(-24'sd777, 16'sd12345, 1'b1);
    await_start;
    respond(24'sd99, 0);
    check("to_sticky", 24'(timeout_o), 24'd1);
    clear_i = 1'b1;
    tick;
    clear_i = 1'b0;
    check("to_clear", 24'(timeout_o), 24'd0);
    send(24'sd42, 16'sd16384, 1'b1);
    await_start;
    respond(-24'sd55, 255);
    check("term_done_no_to", 24'(timeout_o), 24'd0);
    for (int i = 0; i < 4; i++) send(24'($urandom), 16'($urandom), 1'b0);
    tick;
    check("pre_rst_busy", 24'(busy_o), 24'd1);
    reset_i = 1'b1;
    tick;
    reset_i = 1'b0;
    check("mid_rst_start", 24'(start_o), 24'd0);
    check("mid_rst_busy", 24'(busy_o), 24'd0);
    check("mid_rst_sample", sample_o, 24'd0);
    check("mid_rst_result", result_o, 24'd0);
    filt_done_i = 1'b1;
    filt_signal_i = 24'sd77;
    tick;
    filt_done_i = 1'b0;
    check("late_done", 24'(result_valid_o), 24'd0);
    repeat (3) tick;
    check("late_result", result_o, 24'd0);
    check("fifo_empty", {22'd0, start_o, busy_o}, 24'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
